mul_issue: RTL
==============

# mul_issue

RV32M multiply issue stage: sits directly upstream of the existing `mul` unit and between it and the execute pipeline. Accepts one MUL/MULH/MULHSU/MULHU request over a valid/ready handshake, drives `mul` (`enable` pulse, `is_signed`, `src`, `sink`), waits for `completed`, selects or corrects the 32-bit result half and presents it downstream with valid/ready. Holds a one-entry product cache so that a MULH/MUL pair on identical operands costs one multiply.

## Interface
- `HOLDOFF`, 40: cycles `in_ready` stays low after reset deassertion, covering an in-flight `mul` op, since `mul` has no reset.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_op`  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `in_a`  in  32  rs1 operand.
- `in_b`  in  32  rs2 operand.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid & out_ready`.
- `out_data`  out  32  result.
- `mul_enable`  out  1  one-cycle start pulse to `mul`.
- `mul_is_signed`  out  1  to `mul.is_signed`.
- `mul_src`, `mul_sink`  out  32 each  operands to `mul`.
- `mul_completed`  in  1  from `mul.completed`.
- `mul_dest`  in  64  from `mul.dest`.

## Operation
- FSM: HOLD → IDLE → (BUSY | DONE) → DONE → IDLE.
- HOLD: counter runs 0..HOLDOFF-1, then IDLE; HOLDOFF=0 → IDLE on first cycle after reset.
- Op class: MUL, MULH → signed; MULHU, MULHSU → unsigned.
- Result: MUL = prod[31:0]; MULH, MULHU = prod[63:32]; MULHSU = prod[63:32] − (a[31] ? b : 0), mod 2^32.
- Cache: key {a, b, class}, 64-bit product, valid bit. Written on `mul_completed` in BUSY. Cleared only by reset.
- IDLE with handshake and cache hit → DONE; result from cache; no `mul_enable`.
- IDLE with handshake and miss → BUSY; operands and class registered.
- BUSY: waits for `mul_completed`; `mul_completed` is ignored in all other states.
- DONE: `out_valid`=1; `out_data` and `out_valid` held stable until `out_ready`, then IDLE.
- `in_ready` = 1 only in IDLE, so at most one request is in flight.
- Reset in any state: returns to HOLD immediately, and any result in flight is discarded.

## Timing
- Reset values: `in_ready` 0, `out_valid` 0, `out_data` 0, `mul_enable` 0, `mul_is_signed` 0, `mul_src`/`mul_sink` 0, cache invalid, HOLD counter 0.
- Accept at cycle T:
  - Miss: `mul_enable`=1 in T+1 only. `mul_src`/`mul_sink`/`mul_is_signed` stable from T+1 until `mul_completed` is sampled.
  - `mul_completed` sampled high at cycle C → `out_valid` at C+1 with registered `out_data`.
  - Hit: `out_valid` at T+1.
- DONE with `out_ready`=1 at cycle D → IDLE at D+1 (`in_ready`=1). No same-cycle accept-while-done.
- All outputs are registered; no combinational in→out paths.

## Structure
- Package `mul_pkg`: `mul_op_t` enum (MUL, MULH, MULHSU, MULHU), `state_t`, constant `XLEN`=32.
- Instantiates nothing. `mul` is instantiated beside it by the parent.
- The MULHSU correction (32-bit subtract) and result-half mux sit in one combinational function in `mul_pkg`, shared with the bench model.

## Test plan
- MUL a=3, b=0xFFFFFFFB → `mul_is_signed`=1, one `mul_enable` pulse, `out_data`=0xFFFFFFF1.
- MULH a=b=0xFFFFFFFF → 0x00000000. MULHU same operands → cache miss, `mul_is_signed`=0, 0xFFFFFFFE.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF. MULHSU a=0x7FFFFFFF, b=2 → 0x00000000.
- MULH a=7, b=9 (0), then MUL a=7, b=9 → no `mul_enable`, `out_valid` one cycle after accept, 0x0000003F.
- `out_ready` low 5 cycles in DONE → `out_valid`/`out_data` stable, `in_ready` 0. Accept resumes the cycle after consume.
- Reset during BUSY:
  - `out_valid` 0 and `in_ready` 0 for exactly HOLDOFF cycles.
  - Stray `mul_completed` in HOLD/IDLE produces no output.
  - Repeat of the prior operands misses the cache.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and result-select helper for the RV32M multiply issue stage.
package mul_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        IDLE = 2'b01,
        BUSY = 2'b10,
        DONE = 2'b11
    } state_t;

    // MUL/MULH run the signed multiplier; MULHU/MULHSU share the unsigned product.
    function automatic logic op_is_signed(input mul_op_t op);
        return (op == MUL) || (op == MULH);
    endfunction

    // Picks the result half; MULHSU corrects the unsigned high word for a negative rs1.
    function automatic logic [XLEN-1:0] mul_select(
        input mul_op_t          op,
        input logic [XLEN-1:0]   a,
        input logic [XLEN-1:0]   b,
        input logic [2*XLEN-1:0] prod
    );
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] result;
        hi = prod[2*XLEN-1:XLEN];
        case (op)
            MUL:     result = prod[XLEN-1:0];
            MULHSU:  result = hi - (a[XLEN-1] ? b : '0);
            default: result = hi;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mul_issue.sv
// Issue stage in front of the mul unit: handshake in, drive mul, select/correct
// the result half, hand it downstream. One-entry product cache skips repeat multiplies.
module mul_issue
    import mul_pkg::*;
#(
    parameter int HOLDOFF = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic              mul_enable,
    output logic              mul_is_signed,
    output logic [XLEN-1:0]   mul_src,
    output logic [XLEN-1:0]   mul_sink,
    input  logic              mul_completed,
    input  logic [2*XLEN-1:0] mul_dest
);

    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    state_t            state_reg;
    logic [CNT_W-1:0]  hold_cnt_reg;
    mul_op_t           op_reg;

    logic              in_ready_reg;
    logic              out_valid_reg;
    logic [XLEN-1:0]   out_data_reg;
    logic              mul_enable_reg;
    logic              mul_is_signed_reg;
    logic [XLEN-1:0]   mul_src_reg;
    logic [XLEN-1:0]   mul_sink_reg;

    logic              cache_valid_reg;
    logic              cache_signed_reg;
    logic [XLEN-1:0]   cache_a_reg;
    logic [XLEN-1:0]   cache_b_reg;
    logic [2*XLEN-1:0] cache_prod_reg;

    mul_op_t           req_op;
    logic              req_signed;
    logic              cache_hit;

    always_comb begin
        req_op     = mul_op_t'(in_op);
        req_signed = op_is_signed(req_op);
        cache_hit  = cache_valid_reg
                  && (cache_a_reg == in_a)
                  && (cache_b_reg == in_b)
                  && (cache_signed_reg == req_signed);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= HOLD;
            hold_cnt_reg      <= '0;
            op_reg            <= MUL;
            in_ready_reg      <= 1'b0;
            out_valid_reg     <= 1'b0;
            out_data_reg      <= '0;
            mul_enable_reg    <= 1'b0;
            mul_is_signed_reg <= 1'b0;
            mul_src_reg       <= '0;
            mul_sink_reg      <= '0;
            cache_valid_reg   <= 1'b0;
            cache_signed_reg  <= 1'b0;
            cache_a_reg       <= '0;
            cache_b_reg       <= '0;
            cache_prod_reg    <= '0;
        end else begin
            case (state_reg)
                // mul has no reset, so give any op it was running time to drain.
                HOLD: begin
                    if ((HOLDOFF == 0) || (hold_cnt_reg == HOLD_LAST)) begin
                        state_reg    <= IDLE;
                        in_ready_reg <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        in_ready_reg <= 1'b0;
                        if (cache_hit) begin
                            out_data_reg  <= mul_select(req_op, in_a, in_b, cache_prod_reg);
                            out_valid_reg <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            op_reg            <= req_op;
                            mul_enable_reg    <= 1'b1;
                            mul_is_signed_reg <= req_signed;
                            mul_src_reg       <= in_a;
                            mul_sink_reg      <= in_b;
                            state_reg         <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    mul_enable_reg <= 1'b0;
                    if (mul_completed) begin
                        cache_valid_reg  <= 1'b1;
                        cache_signed_reg <= mul_is_signed_reg;
                        cache_a_reg      <= mul_src_reg;
                        cache_b_reg      <= mul_sink_reg;
                        cache_prod_reg   <= mul_dest;
                        out_data_reg     <= mul_select(op_reg, mul_src_reg, mul_sink_reg, mul_dest);
                        out_valid_reg    <= 1'b1;
                        state_reg        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= HOLD;
            endcase
        end
    end

    assign in_ready      = in_ready_reg;
    assign out_valid     = out_valid_reg;
    assign out_data      = out_data_reg;
    assign mul_enable    = mul_enable_reg;
    assign mul_is_signed = mul_is_signed_reg;
    assign mul_src       = mul_src_reg;
    assign mul_sink      = mul_sink_reg;

endmodule
